// File: rtl/ram_req_ctrl.sv
// Request/response front-end for a single-port RAM with registered read data.
// Clears the RAM after reset, then issues requests in order and returns read data through a 2-entry buffer.
module ram_req_ctrl #(
    parameter int                    ADDR_WIDTH  = 4,
    parameter int                    DATA_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  init_busy,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    // Both channels are valid/ready: a transfer happens on a rising edge where valid and ready are both high;
    // valid and its payload hold until that edge, and ready never depends on the same-cycle valid.

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   init_cnt;

    logic                    inflight;
    logic [DATA_WIDTH-1:0]   fifo_mem [2];
    logic                    wr_ptr;
    logic                    rd_ptr;
    logic [1:0]              fifo_cnt;

    logic                    running;
    logic [1:0]              outstanding;
    logic                    pop;
    logic                    push;
    logic                    acc;
    logic                    rd_acc;

    assign running     = (state == RUN);
    assign outstanding = {1'b0, inflight} + fifo_cnt;
    assign rsp_valid   = (fifo_cnt != 2'd0);
    assign rsp_rdata   = fifo_mem[rd_ptr];
    assign pop         = rsp_valid & rsp_ready;
    // A same-cycle pop frees a slot, so a full buffer still takes one request per cycle.
    assign req_ready   = running & ((outstanding < 2'd2) | pop);
    assign acc         = req_valid & req_ready;
    assign rd_acc      = acc & ~req_we;
    // Data for the read issued last cycle is on ram_dout now.
    assign push        = inflight;

    always_comb begin
        ram_we   = acc & req_we;
        ram_addr = req_addr;
        ram_din  = req_wdata;
        if (state == INIT) begin
            ram_we   = ~rst;
            ram_addr = init_cnt;
            ram_din  = CLEAR_VALUE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= INIT;
            init_cnt  <= '0;
            init_busy <= 1'b1;
        end else begin
            case (state)
                INIT: begin
                    init_cnt <= init_cnt + 1'b1;
                    if (init_cnt == LAST_ADDR) begin
                        state     <= RUN;
                        init_busy <= 1'b0;
                    end
                end
                RUN: begin
                    state <= RUN;
                end
                default: begin
                    state <= INIT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= 1'b0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            fifo_cnt <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            inflight <= rd_acc;
            if (push) begin
                fifo_mem[wr_ptr] <= ram_dout;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

endmodule

// File: doc/ram_req_ctrl.md
# ram_req_ctrl

Request/response front-end that sits directly upstream of the single-port RAM (ADDR_WIDTH/DATA_WIDTH generics, registered read data, `dout` held on write cycles). After reset it clears every RAM word to a constant. It then accepts write and read requests over a valid/ready channel, issues them to the RAM, and returns read data in request order over a second valid/ready channel. A 2-entry response buffer sustains one request per cycle while `rsp_ready` is high.

## Interface
- `ADDR_WIDTH`, default 4: RAM address width; depth is DEPTH = 2**ADDR_WIDTH.
- `DATA_WIDTH`, default 8: data width.
- `CLEAR_VALUE`, default 0: value written to every word during init.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted this cycle when high with `req_valid`.
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  ADDR_WIDTH  request address.
- `req_wdata`  in  DATA_WIDTH  write data; ignored for reads.
- `rsp_valid`  out  1  read response present.
- `rsp_ready`  in  1  consumer takes the response.
- `rsp_rdata`  out  DATA_WIDTH  read data.
- `init_busy`  out  1  clear sweep in progress.
- `ram_we`  out  1  to RAM `we`.
- `ram_addr`  out  ADDR_WIDTH  to RAM `addr`.
- `ram_din`  out  DATA_WIDTH  to RAM `din`.
- `ram_dout`  in  DATA_WIDTH  from RAM `dout`; registered, valid the cycle after a read issue.

## Operation
- **States:** INIT, RUN.
  - Reset enters INIT with `init_cnt` = 0.
  - INIT → RUN on the edge that writes address DEPTH-1.
  - RUN has no exit except reset.
- **INIT:**
  - `ram_we` = 1, `ram_addr` = `init_cnt`, `ram_din` = CLEAR_VALUE.
  - `init_cnt` increments each cycle.
  - `req_ready` = 0 and `init_busy` = 1.
- **RUN, request accepted (`acc` = `req_valid` & `req_ready`):**
  - Combinational pass-through: `ram_we` = `acc` & `req_we`, `ram_addr` = `req_addr`, `ram_din` = `req_wdata`.
  - When no request is accepted, `ram_we` = 0. The RAM then performs a harmless read; that data is never captured.
- **Read tracking:**
  - An accepted read sets the `inflight` flag at the edge.
  - At the next edge, `ram_dout` is pushed into the 2-entry response FIFO, and `inflight` clears unless another read is accepted on that same edge.
- **Outstanding count:** `outstanding` = `inflight` + FIFO count, maximum 2.
- **Ready rule:** `req_ready` = RUN & (`outstanding` < 2 | (`rsp_valid` & `rsp_ready`)).
  - The rule applies to reads and writes alike.
  - `req_ready` does not depend on `req_we` or `req_valid`.
- **Response channel:**
  - `rsp_valid` = FIFO non-empty; `rsp_rdata` = FIFO head.
  - Pop occurs on `rsp_valid` & `rsp_ready`.
  - Responses are returned in read-request order. Writes produce no response.
- **Ordering:** a write to A followed by a read of A on the next accepted cycle returns the new data, because the RAM is single-port and requests are issued in order.

## Timing
- **Reset values:**
  - `req_ready` = 0, `rsp_valid` = 0, `rsp_rdata` = 0, `init_busy` = 1.
  - `ram_we` = 0 while `rst` is high, overriding INIT.
  - FIFO is empty, `inflight` = 0.
- **Init duration:** DEPTH cycles after reset deassertion. `init_busy` falls and `req_ready` may rise in cycle DEPTH+1 (counting the first post-reset cycle as 1).
- **Read latency:** read accepted at edge k → `rsp_valid` = 1 after edge k+1, the earliest.
- **Throughput:** with `rsp_ready` held high, reads sustain 1 per cycle.
- **Backpressure:** with `rsp_ready` low, at most 2 reads are outstanding; `req_ready` drops once `outstanding` = 2.
- **Simultaneous push and pop:** with the FIFO full, pop and push on the same edge keep count = 2 with no data loss.
- **FIFO pointers:** 1-bit, wrap naturally.
- **Reset mid-operation:**
  - In-flight and buffered responses are discarded.
  - The FIFO is emptied and INIT restarts from address 0.
  - Writes already issued before reset are not undone.
- **Stability:** `rsp_valid` and `rsp_rdata` are stable while `rsp_valid` & !`rsp_ready`. Only `acc` may change RAM contents.

## Test plan
- **Init sweep:** ADDR_WIDTH = 4, CLEAR_VALUE = 8'hA5, release reset. Required: `ram_we` high for exactly 16 cycles on addresses 0..15, then `init_busy` = 0 and `req_ready` = 1. A read of address 7 returns 8'hA5.
- **Back-to-back:** write 0x3C to address 2, then read address 2 on the next cycle with `rsp_ready` = 1. Required: `rsp_rdata` = 0x3C, `rsp_valid` one cycle after the read is accepted.
- **Streaming:** 16 consecutive reads of addresses 0..15, each preloaded with `addr` × 3, with `rsp_ready` = 1. Required: `req_ready` stays high and 16 responses arrive in order with values 0, 3, …, 45.
- **Backpressure:** `rsp_ready` = 0, issue 4 reads. Required: only 2 are accepted and `req_ready` = 0. Raising `rsp_ready` drains both in order, then the remaining 2 reads are accepted.
- **Reset mid-stream:** assert `rst` with 2 responses buffered. Required: `rsp_valid` = 0 immediately and a full 16-cycle clear repeats.
- **Random stress:** random valid/ready patterns against a reference memory model. Required: data matches, order is preserved, and no response is dropped or duplicated.
